// File: rtl/axi4s_arb_pkg.sv
// Shared types and limits for the packet-granular AXI4-Stream round-robin arbiter.
package axi4s_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int ARB_MAX_N = 16;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request strictly after `last`, wrapping modulo N.
module rr_picker #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] pick,
  output logic          any
);

  logic [N-1:0] rot;

  // Operand never exceeds 2N-1, so one conditional subtract is a full modulo.
  function automatic logic [IW-1:0] wrap(input int v);
    return (v >= N) ? IW'(v - N) : IW'(v);
  endfunction

  always_comb begin
    rot = '0;
    for (int k = 0; k < N; k++) rot[k] = req[wrap(int'(last) + 1 + k)];
    // Descending scan so the lowest rotated position (nearest after last) wins.
    pick = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) pick = wrap(int'(last) + 1 + k);
    end
    any = |req;
  end

endmodule

// File: rtl/axi4s_rr_arbiter.sv
// N-to-1 AXI4-Stream arbiter: grant locks per packet, registered output tagged with source index.
module axi4s_rr_arbiter
  import axi4s_arb_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int DW = 32,
  localparam int IW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0][DW-1:0] s_tdata,
  input  logic [N-1:0]         s_tlast,
  input  logic [N-1:0]         s_tvalid,
  output logic [N-1:0]         s_tready,
  output logic [DW-1:0]        m_tdata,
  output logic                 m_tlast,
  output logic [IW-1:0]        m_tid,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 busy
);

  if (N < 2 || N > ARB_MAX_N) begin : g_bad_n
    $error("axi4s_rr_arbiter: N must be in 2..%0d", ARB_MAX_N);
  end

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [IW-1:0] id;
  } beat_t;

  arb_state_e    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;
  beat_t         out_q, out_d;
  logic          m_tvalid_q, m_tvalid_d;

  logic [IW-1:0] pick;
  logic          any_req;
  logic          slot_free;
  logic          accept;

  rr_picker #(.N(N)) u_picker (
    .req  (s_tvalid),
    .last (last_q),
    .pick (pick),
    .any  (any_req)
  );

  assign slot_free = ~m_tvalid_q | m_tready;

  // Ready depends only on registered state and m_tready, never on s_tvalid.
  always_comb begin
    s_tready = '0;
    if (state_q == ARB_LOCKED && slot_free) s_tready[grant_q] = 1'b1;
  end

  assign accept = s_tvalid[grant_q] & s_tready[grant_q];

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    out_d      = out_q;
    m_tvalid_d = m_tvalid_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          state_d = ARB_LOCKED;
          grant_d = pick;
          last_d  = pick;
        end
      end
      ARB_LOCKED: begin
        if (accept && s_tlast[grant_q]) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase

    if (accept) begin
      out_d      = '{data: s_tdata[grant_q], last: s_tlast[grant_q], id: grant_q};
      m_tvalid_d = 1'b1;
    end else if (m_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      last_q     <= IW'(N - 1);
      out_q      <= '0;
      m_tvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      out_q      <= out_d;
      m_tvalid_q <= m_tvalid_d;
    end
  end

  assign m_tdata  = out_q.data;
  assign m_tlast  = out_q.last;
  assign m_tid    = out_q.id;
  assign m_tvalid = m_tvalid_q;
  assign busy     = (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_axi4s_rr_arbiter.sv
// Directed bench for axi4s_rr_arbiter with a per-cycle reference model and handshake log checks.
module tb_axi4s_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0][DW-1:0] s_tdata;
  logic [N-1:0]         s_tlast, s_tvalid, s_tready;
  logic [DW-1:0]        m_tdata;
  logic                 m_tlast, m_tvalid, m_tready, busy;
  logic [IW-1:0]        m_tid;

  always #5 clk = ~clk;

  axi4s_rr_arbiter #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tid(m_tid), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .busy(busy)
  );

  typedef struct { logic [DW-1:0] d; logic l; } beat_t;
  typedef struct { int id; logic [DW-1:0] d; logic l; int cyc; } obs_t;

  int       errors = 0;
  int       checks = 0;
  beat_t    srcq [N][$];
  obs_t     log_q[$];
  logic [N-1:0] en  = '1;
  logic [N-1:0] acc = '0;
  int       cyc = 0;
  int       rcnt = 0;
  int       rdy_mode = 0;
  int       t_req = -1;
  int       t_out = -1;

  // Reference model: owning source (-1 = none), rotation pointer, one-deep output slot.
  int            md_owner = -1;
  int            md_last  = N - 1;
  logic          e_v  = 1'b0;
  logic [DW-1:0] e_d  = '0;
  logic          e_l  = 1'b0;
  int            e_id = 0;

  logic          p_stall = 1'b0;
  logic [DW-1:0] p_d;
  logic          p_l;
  logic [IW-1:0] p_id;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : mon
    logic [N-1:0] er;
    logic         took;
    logic         fnd;
    int           nx;
    cyc++;
    er = '0;
    if (md_owner >= 0 && (!e_v || m_tready)) er[md_owner] = 1'b1;
    chk("s_tready", 64'(s_tready), 64'(er));
    chk("busy", 64'(busy), 64'(md_owner >= 0));
    chk("m_tvalid", 64'(m_tvalid), 64'(e_v));
    if (e_v) begin
      chk("m_tdata", 64'(m_tdata), 64'(e_d));
      chk("m_tlast", 64'(m_tlast), 64'(e_l));
      chk("m_tid", 64'(m_tid), 64'(e_id));
    end
    if (m_tvalid && !m_tready) chk("stall_s_tready", 64'(s_tready), 64'(0));
    if (p_stall) begin
      chk("stall_valid", 64'(m_tvalid), 64'(1));
      chk("stall_data", 64'({m_tdata, m_tlast, m_tid}), 64'({p_d, p_l, p_id}));
    end
    if (t_req < 0 && s_tvalid != '0) t_req = cyc;
    if (t_out < 0 && m_tvalid) t_out = cyc;
    if (!rst && m_tvalid && m_tready) log_q.push_back('{int'(m_tid), m_tdata, m_tlast, cyc});
    acc     = rst ? '0 : (s_tvalid & s_tready);
    p_stall = m_tvalid & ~m_tready & ~rst;
    p_d = m_tdata; p_l = m_tlast; p_id = m_tid;

    if (rst) begin
      md_owner = -1; md_last = N - 1;
      e_v = 1'b0; e_d = '0; e_l = 1'b0; e_id = 0;
    end else begin
      took = (md_owner >= 0) && er[md_owner] && s_tvalid[md_owner];
      if (took) begin
        e_v = 1'b1; e_d = s_tdata[md_owner]; e_l = s_tlast[md_owner]; e_id = md_owner;
        if (s_tlast[md_owner]) md_owner = -1;
      end else begin
        if (m_tready) e_v = 1'b0;
        if (md_owner < 0) begin
          fnd = 1'b0;
          for (int k = 1; k <= N; k++) begin
            nx = (md_last + k) % N;
            if (!fnd && s_tvalid[nx]) begin
              fnd = 1'b1; md_owner = nx; md_last = nx;
            end
          end
        end
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_tvalid[i] = en[i] && (srcq[i].size() > 0);
      s_tdata[i]  = (srcq[i].size() > 0) ? srcq[i][0].d : '0;
      s_tlast[i]  = (srcq[i].size() > 0) ? srcq[i][0].l : 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++)
      if (acc[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    rcnt++;
    m_tready = (rdy_mode == 0) ? 1'b1 : ((rcnt % 4) == 3);
    drive();
  endtask

  task automatic push_pkt(input int src, input int n, input logic [DW-1:0] base);
    for (int b = 0; b < n; b++) srcq[src].push_back('{base + DW'(b), b == n - 1});
  endtask

  function automatic logic pending();
    logic p;
    p = m_tvalid | busy;
    for (int i = 0; i < N; i++) if (srcq[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_done(input string nm, input int limit);
    int n;
    n = 0;
    while (pending() && n < limit) begin tick(); n++; end
    if (n >= limit) begin
      checks++; errors++;
      $display("FAIL %s: timeout after %0d cycles", nm, limit);
    end
    tick(); tick();
  endtask

  task automatic wait_size(input int src, input int sz, input int limit);
    int n;
    n = 0;
    while (srcq[src].size() > sz && n < limit) begin tick(); n++; end
    if (n >= limit) begin
      checks++; errors++;
      $display("FAIL wait_src%0d: timeout, %0d beats left", src, srcq[src].size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) srcq[i].delete();
    drive();
    tick(); tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    int cnt [N];
    rst = 1'b1; m_tready = 1'b1;
    s_tdata = '0; s_tlast = '0; s_tvalid = '0;

    // Reset then idle
    do_reset();
    repeat (20) tick();
    chk("idle_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_s_tready", 64'(s_tready), 64'(0));

    // Single source, 4-beat packet
    log_q.delete(); t_req = -1; t_out = -1;
    push_pkt(2, 4, 32'hA0); drive();
    wait_done("single", 50);
    chk("latency", 64'(t_out - t_req), 64'(2));
    chk("single_len", 64'(log_q.size()), 64'(4));
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      chk("single_data", 64'(log_q[i].d), 64'(32'hA0 + i));
      chk("single_id", 64'(log_q[i].id), 64'(2));
      chk("single_last", 64'(log_q[i].l), 64'(i == 3));
      if (i > 0) chk("single_b2b", 64'(log_q[i].cyc - log_q[i-1].cyc), 64'(1));
    end

    // Fairness: 4 sources, 10 two-beat packets each
    do_reset();
    log_q.delete();
    for (int p = 0; p < 10; p++)
      for (int s = 0; s < N; s++) push_pkt(s, 2, 32'h1000 * s + 32'h10 * p);
    drive();
    wait_done("fair", 400);
    chk("fair_len", 64'(log_q.size()), 64'(80));
    for (int s = 0; s < N; s++) cnt[s] = 0;
    for (int j = 0; j < 80 && j < log_q.size(); j++) begin
      int k;
      k = j / 2;
      chk("fair_id", 64'(log_q[j].id), 64'(k % 4));
      chk("fair_data", 64'(log_q[j].d), 64'(32'h1000 * (k % 4) + 32'h10 * (k / 4) + (j % 2)));
      chk("fair_last", 64'(log_q[j].l), 64'(j % 2));
      if (log_q[j].l) cnt[log_q[j].id]++;
    end
    for (int s = 0; s < N; s++) chk("fair_count", 64'(cnt[s]), 64'(10));

    // Backpressure: 3-low/1-high ready during an 8-beat packet
    log_q.delete(); rdy_mode = 1; rcnt = 0;
    push_pkt(1, 8, 32'hB0); drive();
    wait_done("bp", 200);
    rdy_mode = 0; tick();
    chk("bp_len", 64'(log_q.size()), 64'(8));
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      chk("bp_data", 64'(log_q[i].d), 64'(32'hB0 + i));
      chk("bp_id", 64'(log_q[i].id), 64'(1));
    end

    // Lock hold: source 0 pauses mid-packet while source 3 requests
    log_q.delete();
    push_pkt(0, 6, 32'hC0); drive();
    wait_size(0, 4, 50);
    en[0] = 1'b0;
    push_pkt(3, 2, 32'hD0); drive();
    repeat (5) begin
      tick();
      chk("hold_busy", 64'(busy), 64'(1));
      chk("hold_no_s3", 64'(s_tready[3]), 64'(0));
    end
    en[0] = 1'b1; drive();
    wait_done("hold", 100);
    chk("hold_len", 64'(log_q.size()), 64'(8));
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      chk("hold_id", 64'(log_q[i].id), 64'((i < 6) ? 0 : 3));
      chk("hold_data", 64'(log_q[i].d), 64'((i < 6) ? 32'hC0 + i : 32'hD0 + i - 6));
    end

    // Reset mid-packet
    push_pkt(1, 6, 32'hE0); drive();
    wait_size(1, 3, 50);
    rst = 1'b1;
    for (int i = 0; i < N; i++) srcq[i].delete();
    drive();
    tick();
    chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_s_tready", 64'(s_tready), 64'(0));
    tick();
    rst = 1'b0;
    log_q.delete();
    push_pkt(2, 1, 32'hF2); push_pkt(1, 1, 32'hF1); push_pkt(0, 1, 32'hF0); drive();
    wait_done("post_rst", 50);
    chk("post_rst_len", 64'(log_q.size()), 64'(3));
    for (int i = 0; i < 3 && i < log_q.size(); i++) begin
      chk("post_rst_id", 64'(log_q[i].id), 64'(i));
      chk("post_rst_data", 64'(log_q[i].d), 64'(32'hF0 + i));
      chk("post_rst_last", 64'(log_q[i].l), 64'(1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
